// File: rtl/scr1_fprf_ctrl_pkg.sv
// Shared types for the FP register file controller: register address,
// register count and the write-source encoding used by arbitration.
package scr1_fprf_ctrl_pkg;

   localparam int SCR1_FPRF_NREGS = 32;

   typedef logic [4:0] type_scr1_fprf_addr_e;

   // Encoding doubles as the bit index of the one-hot grant vector.
   typedef enum logic {
      SCR1_FPRF_WSRC_FPU = 1'b0,
      SCR1_FPRF_WSRC_LSU = 1'b1
   } type_scr1_fprf_wsrc_e;

endpackage

// File: rtl/scr1_pipe_fprf_ctrl_if.sv
// Bundle of issue, writeback, FPRF write-port and FS signals of the FPRF controller.
// Writeback channels: a requester raises *_wb_vd_i and keeps vd/addr/data stable until it sees *_wb_rdy_o high.
interface scr1_pipe_fprf_ctrl_if
   import scr1_fprf_ctrl_pkg::*;
#(
   parameter int DATA_W = 32
);
   logic                         issue_vd_i;
   logic [2:0]                   issue_rs_use_i;
   type_scr1_fprf_addr_e         issue_rs1_addr_i;
   type_scr1_fprf_addr_e         issue_rs2_addr_i;
   type_scr1_fprf_addr_e         issue_rs3_addr_i;
   logic                         issue_rd_we_i;
   type_scr1_fprf_addr_e         issue_rd_addr_i;
   logic                         issue_stall_o;

   logic                         fpu_wb_vd_i;
   type_scr1_fprf_addr_e         fpu_wb_addr_i;
   logic [DATA_W-1:0]            fpu_wb_data_i;
   logic                         fpu_wb_rdy_o;

   logic                         lsu_wb_vd_i;
   type_scr1_fprf_addr_e         lsu_wb_addr_i;
   logic [DATA_W-1:0]            lsu_wb_data_i;
   logic                         lsu_wb_rdy_o;

   logic                         fprf_w_req_o;
   type_scr1_fprf_addr_e         fprf_rd_addr_o;
   logic [DATA_W-1:0]            fprf_rd_data_o;

   logic                         fs_clean_i;
   logic                         fs_dirty_o;
   logic [SCR1_FPRF_NREGS-1:0]   busy_o;

   modport master (
      output issue_vd_i, issue_rs_use_i, issue_rs1_addr_i, issue_rs2_addr_i, issue_rs3_addr_i,
      output issue_rd_we_i, issue_rd_addr_i,
      output fpu_wb_vd_i, fpu_wb_addr_i, fpu_wb_data_i,
      output lsu_wb_vd_i, lsu_wb_addr_i, lsu_wb_data_i,
      output fs_clean_i,
      input  issue_stall_o, fpu_wb_rdy_o, lsu_wb_rdy_o,
      input  fprf_w_req_o, fprf_rd_addr_o, fprf_rd_data_o, fs_dirty_o, busy_o
   );

   modport slave (
      input  issue_vd_i, issue_rs_use_i, issue_rs1_addr_i, issue_rs2_addr_i, issue_rs3_addr_i,
      input  issue_rd_we_i, issue_rd_addr_i,
      input  fpu_wb_vd_i, fpu_wb_addr_i, fpu_wb_data_i,
      input  lsu_wb_vd_i, lsu_wb_addr_i, lsu_wb_data_i,
      input  fs_clean_i,
      output issue_stall_o, fpu_wb_rdy_o, lsu_wb_rdy_o,
      output fprf_w_req_o, fprf_rd_addr_o, fprf_rd_data_o, fs_dirty_o, busy_o
   );

endinterface

// File: rtl/scr1_fprf_wb_arb.sv
// Two-way FPRF write-port arbiter: combinational one-hot grant, optional
// round-robin using the last granted source as the pointer.
module scr1_fprf_wb_arb
   import scr1_fprf_ctrl_pkg::*;
#(
   parameter bit ARB_RR = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       fpu_vd,
   input  logic       lsu_vd,
   output logic [1:0] gnt      // {lsu, fpu}
);

   type_scr1_fprf_wsrc_e rr_ptr;

   always_comb begin
      gnt = 2'b00;
      if (!rst) begin
         if (fpu_vd && lsu_vd) begin
            // Contention: round-robin hands the port to the side not granted last.
            if (ARB_RR && (rr_ptr == SCR1_FPRF_WSRC_LSU)) gnt = 2'b01;
            else                                          gnt = 2'b10;
         end else if (fpu_vd) begin
            gnt = 2'b01;
         end else if (lsu_vd) begin
            gnt = 2'b10;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)         rr_ptr <= SCR1_FPRF_WSRC_FPU;
      else if (gnt[1]) rr_ptr <= SCR1_FPRF_WSRC_LSU;
      else if (gnt[0]) rr_ptr <= SCR1_FPRF_WSRC_FPU;
   end

endmodule

// File: rtl/scr1_pipe_fprf_ctrl.sv
// FPRF controller: busy scoreboard with RAW/WAW issue stall, single write
// port shared by FPU results and FP loads, and the mstatus.FS dirty flag.
module scr1_pipe_fprf_ctrl
   import scr1_fprf_ctrl_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter bit ARB_RR = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   scr1_pipe_fprf_ctrl_if.slave bus
);

   logic [SCR1_FPRF_NREGS-1:0] busy;
   logic [SCR1_FPRF_NREGS-1:0] busy_nxt;
   logic [1:0]                 gnt;
   logic                       raw;
   logic                       waw;
   logic                       stall;
   logic                       do_set;
   logic                       w_req;
   type_scr1_fprf_addr_e       waddr;
   logic [DATA_W-1:0]          wdata;
   logic                       fs_dirty;

   scr1_fprf_wb_arb #(.ARB_RR(ARB_RR)) i_wb_arb (
      .clk    (clk),
      .rst    (rst),
      .fpu_vd (bus.fpu_wb_vd_i),
      .lsu_vd (bus.lsu_wb_vd_i),
      .gnt    (gnt)
   );

   // No bypass: a register being written this cycle still counts as busy.
   assign raw = (bus.issue_rs_use_i[0] && busy[bus.issue_rs1_addr_i])
             || (bus.issue_rs_use_i[1] && busy[bus.issue_rs2_addr_i])
             || (bus.issue_rs_use_i[2] && busy[bus.issue_rs3_addr_i]);
   assign waw    = bus.issue_rd_we_i && busy[bus.issue_rd_addr_i];
   assign stall  = !rst && bus.issue_vd_i && (raw || waw);
   assign do_set = bus.issue_vd_i && !stall && bus.issue_rd_we_i;

   assign w_req = |gnt;

   always_comb begin
      waddr = '0;
      wdata = '0;
      if (gnt[1]) begin
         waddr = bus.lsu_wb_addr_i;
         wdata = bus.lsu_wb_data_i;
      end else if (gnt[0]) begin
         waddr = bus.fpu_wb_addr_i;
         wdata = bus.fpu_wb_data_i;
      end
   end

   // Clear first, then set, so an (illegal) same-register collision leaves it busy.
   always_comb begin
      busy_nxt = busy;
      if (w_req)  busy_nxt[waddr] = 1'b0;
      if (do_set) busy_nxt[bus.issue_rd_addr_i] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) busy <= '0;
      else     busy <= busy_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst)                 fs_dirty <= 1'b0;
      else if (w_req)          fs_dirty <= 1'b1;
      else if (bus.fs_clean_i) fs_dirty <= 1'b0;
   end

   // A writeback must target a register the scoreboard holds busy.
   wb_to_idle_reg: assert property (@(posedge clk) disable iff (rst) w_req |-> busy[waddr]);

   assign bus.issue_stall_o  = stall;
   assign bus.fpu_wb_rdy_o   = gnt[0];
   assign bus.lsu_wb_rdy_o   = gnt[1];
   assign bus.fprf_w_req_o   = w_req;
   assign bus.fprf_rd_addr_o = waddr;
   assign bus.fprf_rd_data_o = wdata;
   assign bus.fs_dirty_o     = fs_dirty;
   assign bus.busy_o         = busy;

endmodule

// File: tb/tb_scr1_pipe_fprf_ctrl.sv
// Bench for scr1_pipe_fprf_ctrl: directed scenarios plus a randomized run
// against a register-level model of the scoreboard, arbitration and FS flag.
module tb_scr1_pipe_fprf_ctrl;
   import scr1_fprf_ctrl_pkg::*;

   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   scr1_pipe_fprf_ctrl_if #(.DATA_W(DW)) ifr ();
   scr1_pipe_fprf_ctrl_if #(.DATA_W(DW)) ifp ();

   scr1_pipe_fprf_ctrl #(.DATA_W(DW), .ARB_RR(1'b1)) dut_rr (.clk(clk), .rst(rst), .bus(ifr));
   scr1_pipe_fprf_ctrl #(.DATA_W(DW), .ARB_RR(1'b0)) dut_fp (.clk(clk), .rst(rst), .bus(ifp));

   int errors = 0;
   int checks = 0;

   // Model of the round-robin instance: busy set, dirty flag, last granted (1 = LSU).
   logic [31:0] mbusy = '0;
   logic        mdirty = 1'b0;
   logic        mlast = 1'b0;

   function automatic logic exp_stall();
      logic [4:0] rs [3];
      rs[0] = ifr.issue_rs1_addr_i;
      rs[1] = ifr.issue_rs2_addr_i;
      rs[2] = ifr.issue_rs3_addr_i;
      if (rst || !ifr.issue_vd_i) return 1'b0;
      for (int k = 0; k < 3; k++)
         if (ifr.issue_rs_use_i[k] && mbusy[rs[k]]) return 1'b1;
      if (ifr.issue_rd_we_i && mbusy[ifr.issue_rd_addr_i]) return 1'b1;
      return 1'b0;
   endfunction

   // Returns {lsu, fpu} grant expected for the current inputs.
   function automatic logic [1:0] exp_gnt();
      if (rst) return 2'b00;
      if (ifr.fpu_wb_vd_i && ifr.lsu_wb_vd_i) return mlast ? 2'b01 : 2'b10;
      if (ifr.fpu_wb_vd_i) return 2'b01;
      if (ifr.lsu_wb_vd_i) return 2'b10;
      return 2'b00;
   endfunction

   // Advance one clock and apply the same edge to the model.
   task automatic tick();
      logic       st;
      logic [1:0] g;
      st = exp_stall();
      g  = exp_gnt();
      @(posedge clk);
      if (rst) begin
         mbusy = '0; mdirty = 1'b0; mlast = 1'b0;
      end else begin
         if (g != 2'b00) begin
            mbusy[g[1] ? ifr.lsu_wb_addr_i : ifr.fpu_wb_addr_i] = 1'b0;
            mdirty = 1'b1;
            mlast  = g[1];
         end else if (ifr.fs_clean_i) begin
            mdirty = 1'b0;
         end
         if (ifr.issue_vd_i && !st && ifr.issue_rd_we_i) mbusy[ifr.issue_rd_addr_i] = 1'b1;
      end
      #1;
   endtask

   task automatic clear_inputs();
      ifr.issue_vd_i = 0; ifr.issue_rs_use_i = 0; ifr.issue_rs1_addr_i = 0; ifr.issue_rs2_addr_i = 0;
      ifr.issue_rs3_addr_i = 0; ifr.issue_rd_we_i = 0; ifr.issue_rd_addr_i = 0;
      ifr.fpu_wb_vd_i = 0; ifr.fpu_wb_addr_i = 0; ifr.fpu_wb_data_i = 0;
      ifr.lsu_wb_vd_i = 0; ifr.lsu_wb_addr_i = 0; ifr.lsu_wb_data_i = 0; ifr.fs_clean_i = 0;
      ifp.issue_vd_i = 0; ifp.issue_rs_use_i = 0; ifp.issue_rs1_addr_i = 0; ifp.issue_rs2_addr_i = 0;
      ifp.issue_rs3_addr_i = 0; ifp.issue_rd_we_i = 0; ifp.issue_rd_addr_i = 0;
      ifp.fpu_wb_vd_i = 0; ifp.fpu_wb_addr_i = 0; ifp.fpu_wb_data_i = 0;
      ifp.lsu_wb_vd_i = 0; ifp.lsu_wb_addr_i = 0; ifp.lsu_wb_data_i = 0; ifp.fs_clean_i = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic issue_wr(input logic [4:0] rd);
      ifr.issue_vd_i = 1; ifr.issue_rd_we_i = 1; ifr.issue_rd_addr_i = rd; ifr.issue_rs_use_i = 0;
      tick();
      ifr.issue_vd_i = 0; ifr.issue_rd_we_i = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      ifr.issue_vd_i = 1; ifr.issue_rd_we_i = 1; ifr.issue_rd_addr_i = 5'd2;
      ifr.fpu_wb_vd_i = 1; ifr.fpu_wb_addr_i = 5'd2; ifr.lsu_wb_vd_i = 1; ifr.lsu_wb_addr_i = 5'd3;
      #1;
      checks++; if (ifr.issue_stall_o !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", ifr.issue_stall_o); end
      checks++; if ({ifr.lsu_wb_rdy_o, ifr.fpu_wb_rdy_o} !== 2'b00) begin errors++; $display("FAIL rst_rdy: got %b want 00", {ifr.lsu_wb_rdy_o, ifr.fpu_wb_rdy_o}); end
      checks++; if (ifr.fprf_w_req_o !== 1'b0) begin errors++; $display("FAIL rst_wreq: got %b want 0", ifr.fprf_w_req_o); end
      tick(); tick();
      clear_inputs();
      rst = 1'b0;
      #1;
      checks++; if (ifr.busy_o !== 32'h0) begin errors++; $display("FAIL rst_busy: got %h want 0", ifr.busy_o); end
      checks++; if (ifr.fs_dirty_o !== 1'b0) begin errors++; $display("FAIL rst_dirty: got %b want 0", ifr.fs_dirty_o); end
   endtask

   task automatic test_raw();
      do_reset();
      issue_wr(5'd5);
      checks++; if (ifr.busy_o[5] !== 1'b1) begin errors++; $display("FAIL raw_busy_set: got %b want 1", ifr.busy_o[5]); end
      ifr.issue_vd_i = 1; ifr.issue_rs_use_i = 3'b001; ifr.issue_rs1_addr_i = 5'd5;
      #1;
      checks++; if (ifr.issue_stall_o !== 1'b1) begin errors++; $display("FAIL raw_stall: got %b want 1", ifr.issue_stall_o); end
      tick();
      ifr.fpu_wb_vd_i = 1; ifr.fpu_wb_addr_i = 5'd5; ifr.fpu_wb_data_i = 32'h3F80_0000;
      #1;
      checks++; if (ifr.issue_stall_o !== 1'b1) begin errors++; $display("FAIL raw_no_bypass: got %b want 1", ifr.issue_stall_o); end
      checks++; if (ifr.fprf_w_req_o !== 1'b1 || ifr.fprf_rd_addr_o !== 5'd5 || ifr.fprf_rd_data_o !== 32'h3F80_0000)
         begin errors++; $display("FAIL raw_write: got req=%b addr=%0d data=%h want 1/5/3f800000", ifr.fprf_w_req_o, ifr.fprf_rd_addr_o, ifr.fprf_rd_data_o); end
      tick();
      ifr.fpu_wb_vd_i = 0;
      #1;
      checks++; if (ifr.issue_stall_o !== 1'b0) begin errors++; $display("FAIL raw_release: got %b want 0", ifr.issue_stall_o); end
      checks++; if (ifr.busy_o[5] !== 1'b0) begin errors++; $display("FAIL raw_busy_clr: got %b want 0", ifr.busy_o[5]); end
      tick();
      clear_inputs();
   endtask

   task automatic test_waw();
      do_reset();
      issue_wr(5'd7);
      ifr.issue_vd_i = 1; ifr.issue_rd_we_i = 1; ifr.issue_rd_addr_i = 5'd7;
      #1;
      checks++; if (ifr.issue_stall_o !== 1'b1) begin errors++; $display("FAIL waw_stall: got %b want 1", ifr.issue_stall_o); end
      tick();
      ifr.lsu_wb_vd_i = 1; ifr.lsu_wb_addr_i = 5'd7; ifr.lsu_wb_data_i = 32'hCAFE_0007;
      #1;
      checks++; if (ifr.issue_stall_o !== 1'b1 || ifr.lsu_wb_rdy_o !== 1'b1)
         begin errors++; $display("FAIL waw_wb: got stall=%b rdy=%b want 1/1", ifr.issue_stall_o, ifr.lsu_wb_rdy_o); end
      tick();
      ifr.lsu_wb_vd_i = 0;
      #1;
      checks++; if (ifr.issue_stall_o !== 1'b0) begin errors++; $display("FAIL waw_release: got %b want 0", ifr.issue_stall_o); end
      tick();
      clear_inputs();
      #1;
      checks++; if (ifr.busy_o[7] !== 1'b1) begin errors++; $display("FAIL waw_reset_busy: got %b want 1", ifr.busy_o[7]); end
   endtask

   task automatic test_rr_alternate();
      logic [4:0]  fq [$];
      logic [4:0]  lq [$];
      logic [31:0] fd [$];
      logic [31:0] ld [$];
      logic        exp_seq [5];
      logic [4:0]  ea;
      exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      do_reset();
      for (int r = 10; r < 15; r++) issue_wr(5'(r));
      fq = '{5'd10, 5'd11}; lq = '{5'd12, 5'd13, 5'd14};
      for (int i = 0; i < 2; i++) fd.push_back($urandom);
      for (int i = 0; i < 3; i++) ld.push_back($urandom);
      for (int c = 0; c < 5; c++) begin
         ifr.fpu_wb_vd_i = (fq.size() != 0); ifr.lsu_wb_vd_i = (lq.size() != 0);
         if (fq.size() != 0) begin ifr.fpu_wb_addr_i = fq[0]; ifr.fpu_wb_data_i = fd[0]; end
         if (lq.size() != 0) begin ifr.lsu_wb_addr_i = lq[0]; ifr.lsu_wb_data_i = ld[0]; end
         ea = exp_seq[c] ? lq[0] : fq[0];
         #1;
         checks++; if (ifr.lsu_wb_rdy_o !== exp_seq[c] || ifr.fpu_wb_rdy_o !== !exp_seq[c])
            begin errors++; $display("FAIL rr_grant c=%0d: got lsu=%b fpu=%b want lsu=%b", c, ifr.lsu_wb_rdy_o, ifr.fpu_wb_rdy_o, exp_seq[c]); end
         checks++; if (ifr.fprf_rd_addr_o !== ea || ifr.fprf_rd_data_o !== (exp_seq[c] ? ld[0] : fd[0]))
            begin errors++; $display("FAIL rr_write c=%0d: got addr=%0d data=%h want addr=%0d", c, ifr.fprf_rd_addr_o, ifr.fprf_rd_data_o, ea); end
         tick();
         if (exp_seq[c]) begin void'(lq.pop_front()); void'(ld.pop_front()); end
         else            begin void'(fq.pop_front()); void'(fd.pop_front()); end
      end
      clear_inputs();
      #1;
      checks++; if (ifr.busy_o !== 32'h0) begin errors++; $display("FAIL rr_busy_drained: got %h want 0", ifr.busy_o); end
   endtask

   task automatic test_fixed_prio();
      do_reset();
      for (int r = 20; r < 24; r++) begin
         ifp.issue_vd_i = 1; ifp.issue_rd_we_i = 1; ifp.issue_rd_addr_i = 5'(r);
         tick();
      end
      ifp.issue_vd_i = 0; ifp.issue_rd_we_i = 0;
      ifp.fpu_wb_vd_i = 1; ifp.fpu_wb_addr_i = 5'd23; ifp.fpu_wb_data_i = $urandom;
      for (int c = 0; c < 3; c++) begin
         ifp.lsu_wb_vd_i = 1; ifp.lsu_wb_addr_i = 5'(20 + c); ifp.lsu_wb_data_i = $urandom;
         #1;
         checks++; if (ifp.lsu_wb_rdy_o !== 1'b1 || ifp.fpu_wb_rdy_o !== 1'b0 || ifp.fprf_rd_addr_o !== 5'(20 + c))
            begin errors++; $display("FAIL fix_lsu_wins c=%0d: got lsu=%b fpu=%b addr=%0d want 1/0/%0d", c, ifp.lsu_wb_rdy_o, ifp.fpu_wb_rdy_o, ifp.fprf_rd_addr_o, 20 + c); end
         tick();
      end
      ifp.lsu_wb_vd_i = 0;
      #1;
      checks++; if (ifp.fpu_wb_rdy_o !== 1'b1 || ifp.fprf_rd_addr_o !== 5'd23)
         begin errors++; $display("FAIL fix_fpu_after: got rdy=%b addr=%0d want 1/23", ifp.fpu_wb_rdy_o, ifp.fprf_rd_addr_o); end
      tick();
      clear_inputs();
      #1;
      checks++; if (ifp.busy_o !== 32'h0) begin errors++; $display("FAIL fix_busy_drained: got %h want 0", ifp.busy_o); end
   endtask

   task automatic test_fs_dirty();
      do_reset();
      checks++; if (ifr.fs_dirty_o !== 1'b0) begin errors++; $display("FAIL fs_after_rst: got %b want 0", ifr.fs_dirty_o); end
      issue_wr(5'd4);
      ifr.fpu_wb_vd_i = 1; ifr.fpu_wb_addr_i = 5'd4; ifr.fpu_wb_data_i = 32'h1;
      tick();
      ifr.fpu_wb_vd_i = 0;
      checks++; if (ifr.fs_dirty_o !== 1'b1) begin errors++; $display("FAIL fs_first_grant: got %b want 1", ifr.fs_dirty_o); end
      ifr.fs_clean_i = 1;
      tick();
      ifr.fs_clean_i = 0;
      checks++; if (ifr.fs_dirty_o !== 1'b0) begin errors++; $display("FAIL fs_clean: got %b want 0", ifr.fs_dirty_o); end
      issue_wr(5'd6);
      ifr.lsu_wb_vd_i = 1; ifr.lsu_wb_addr_i = 5'd6; ifr.lsu_wb_data_i = 32'h2; ifr.fs_clean_i = 1;
      tick();
      clear_inputs();
      checks++; if (ifr.fs_dirty_o !== 1'b1) begin errors++; $display("FAIL fs_clean_vs_grant: got %b want 1", ifr.fs_dirty_o); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      issue_wr(5'd3);
      issue_wr(5'd9);
      checks++; if (ifr.busy_o !== 32'h0000_0208) begin errors++; $display("FAIL mid_busy: got %h want 00000208", ifr.busy_o); end
      rst = 1'b1;
      ifr.issue_vd_i = 1; ifr.issue_rs_use_i = 3'b001; ifr.issue_rs1_addr_i = 5'd3;
      ifr.fpu_wb_vd_i = 1; ifr.fpu_wb_addr_i = 5'd3; ifr.lsu_wb_vd_i = 1; ifr.lsu_wb_addr_i = 5'd9;
      #1;
      checks++; if (ifr.issue_stall_o !== 1'b0 || ifr.fpu_wb_rdy_o !== 1'b0 || ifr.lsu_wb_rdy_o !== 1'b0)
         begin errors++; $display("FAIL mid_outputs_in_rst: got stall=%b fpu=%b lsu=%b want 0/0/0", ifr.issue_stall_o, ifr.fpu_wb_rdy_o, ifr.lsu_wb_rdy_o); end
      tick();
      rst = 1'b0;
      ifr.fpu_wb_vd_i = 0; ifr.lsu_wb_vd_i = 0;
      #1;
      checks++; if (ifr.busy_o !== 32'h0 || ifr.issue_stall_o !== 1'b0)
         begin errors++; $display("FAIL mid_after_rst: got busy=%h stall=%b want 0/0", ifr.busy_o, ifr.issue_stall_o); end
      tick();
      clear_inputs();
   endtask

   task automatic test_random();
      logic        fa, la;
      logic [4:0]  fad, lad, r;
      logic [31:0] fdt, ldt, edata;
      logic [4:0]  eaddr;
      logic [1:0]  eg;
      logic        es;
      do_reset();
      fa = 0; la = 0; fad = 0; lad = 0; fdt = 0; ldt = 0;
      for (int i = 0; i < 400; i++) begin
         if (!fa && $urandom_range(0, 2) != 0)
            for (int t = 0; t < 8 && !fa; t++) begin
               r = 5'($urandom_range(0, 31));
               if (mbusy[r] && !(la && lad == r)) begin fa = 1; fad = r; fdt = $urandom; end
            end
         if (!la && $urandom_range(0, 2) != 0)
            for (int t = 0; t < 8 && !la; t++) begin
               r = 5'($urandom_range(0, 31));
               if (mbusy[r] && !(fa && fad == r)) begin la = 1; lad = r; ldt = $urandom; end
            end
         rst = ($urandom_range(0, 63) == 0);
         ifr.fpu_wb_vd_i = fa; ifr.fpu_wb_addr_i = fad; ifr.fpu_wb_data_i = fdt;
         ifr.lsu_wb_vd_i = la; ifr.lsu_wb_addr_i = lad; ifr.lsu_wb_data_i = ldt;
         ifr.issue_vd_i = 1'($urandom_range(0, 1));
         ifr.issue_rs_use_i = 3'($urandom_range(0, 7));
         ifr.issue_rs1_addr_i = 5'($urandom_range(0, 15));
         ifr.issue_rs2_addr_i = 5'($urandom_range(0, 15));
         ifr.issue_rs3_addr_i = 5'($urandom_range(0, 15));
         ifr.issue_rd_we_i = 1'($urandom_range(0, 1));
         ifr.issue_rd_addr_i = 5'($urandom_range(0, 15));
         ifr.fs_clean_i = ($urandom_range(0, 7) == 0);
         #1;
         es = exp_stall();
         eg = exp_gnt();
         eaddr = eg[1] ? lad : (eg[0] ? fad : 5'd0);
         edata = eg[1] ? ldt : (eg[0] ? fdt : 32'd0);
         checks++; if (ifr.issue_stall_o !== es) begin errors++; $display("FAIL rnd_stall i=%0d: got %b want %b", i, ifr.issue_stall_o, es); end
         checks++; if ({ifr.lsu_wb_rdy_o, ifr.fpu_wb_rdy_o} !== eg) begin errors++; $display("FAIL rnd_grant i=%0d: got %b want %b", i, {ifr.lsu_wb_rdy_o, ifr.fpu_wb_rdy_o}, eg); end
         checks++; if (ifr.fprf_w_req_o !== (|eg) || ifr.fprf_rd_addr_o !== eaddr || ifr.fprf_rd_data_o !== edata)
            begin errors++; $display("FAIL rnd_write i=%0d: got %b/%0d/%h want %b/%0d/%h", i, ifr.fprf_w_req_o, ifr.fprf_rd_addr_o, ifr.fprf_rd_data_o, |eg, eaddr, edata); end
         checks++; if (ifr.busy_o !== mbusy) begin errors++; $display("FAIL rnd_busy i=%0d: got %h want %h", i, ifr.busy_o, mbusy); end
         checks++; if (ifr.fs_dirty_o !== mdirty) begin errors++; $display("FAIL rnd_dirty i=%0d: got %b want %b", i, ifr.fs_dirty_o, mdirty); end
         tick();
         if (eg[0] || rst) fa = 0;
         if (eg[1] || rst) la = 0;
      end
      rst = 1'b0;
      clear_inputs();
   endtask

   initial begin
      rst = 1'b1;
      test_reset();
      test_raw();
      test_waw();
      test_rr_alternate();
      test_fixed_prio();
      test_fs_dirty();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/scr1_pipe_fprf_ctrl.md
Name: scr1_pipe_fprf_ctrl

Overview:
Controller for the FP register file (FPRF) in the SCR1 pipeline.
- Keeps a 32-entry busy scoreboard of pending FP writes and produces the issue-stage stall for RAW/WAW hazards.
- Arbitrates the single FPRF write port between the multi-cycle FPU result and LSU FLW load-return data.
- Drives the FPRF w_req/rd_addr/rd_data inputs directly and maintains the mstatus.FS "dirty" indication.

Parameters:
DATA_W, 32, FP data width; equals `SCR1_XLEN.
ARB_RR, 1, 1 = round-robin write arbitration; 0 = fixed priority with the LSU winning.

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
issue_vd_i  in  1  FP-related instruction presented at issue
issue_rs_use_i  in  3  read-use mask {rs3,rs2,rs1}
issue_rs1_addr_i  in  5  FP source 1 address
issue_rs2_addr_i  in  5  FP source 2 address
issue_rs3_addr_i  in  5  FP source 3 address (FMA)
issue_rd_we_i  in  1  instruction writes an FP rd
issue_rd_addr_i  in  5  FP destination address
issue_stall_o  out  1  hazard; instruction must hold
fpu_wb_vd_i  in  1  FPU result valid
fpu_wb_addr_i  in  5  FPU destination
fpu_wb_data_i  in  DATA_W  FPU result
fpu_wb_rdy_o  out  1  FPU result accepted this cycle
lsu_wb_vd_i  in  1  FP load data valid
lsu_wb_addr_i  in  5  load destination
lsu_wb_data_i  in  DATA_W  load data
lsu_wb_rdy_o  out  1  load data accepted this cycle
fprf_w_req_o  out  1  FPRF write enable
fprf_rd_addr_o  out  5  FPRF write address
fprf_rd_data_o  out  DATA_W  FPRF write data
fs_clean_i  in  1  CSR writes mstatus.FS to Clean/Initial
fs_dirty_o  out  1  an FP register has been written since the last clean
busy_o  out  32  scoreboard, for debug/CSR observation

Behaviour:
Reset (rst=1 at a clk edge):
- busy = 0, fs_dirty_o = 0, RR pointer = FPU.
- Outputs during reset: issue_stall_o = 0, both rdy = 0, fprf_w_req_o = 0.
- Reset mid-operation drops every pending scoreboard entry; requesters are reset by the same rst.

Hazard / stall:
- issue_stall_o is combinational, asserted when issue_vd_i and any of the following holds:
  - (use[k] && busy[rsk]) for k = 1..3 (RAW);
  - (rd_we && busy[rd]) (WAW).
- No bypass: a register written in cycle N still reads busy in cycle N.
- Its busy bit clears at the edge ending cycle N, so a dependent instruction issues in N+1 at the earliest.
- f0 is an ordinary register and is scoreboarded.

Scoreboard set:
- When issue_vd_i && !issue_stall_o && issue_rd_we_i: busy[rd] <= 1 at the clock edge.

Write arbitration:
- Single-cycle and combinational, grant in the same cycle. Valid/ready rule: a requester holds vd/addr/data stable until its rdy is high.
- Only one requester valid: it is granted.
- Both requesters valid:
  - ARB_RR = 1: grant the side not pointed to by the RR pointer's "last granted" value.
  - ARB_RR = 0: the LSU always wins.
- RR pointer updates to the granted side on each grant; with no grant it holds.
- On a grant:
  - fprf_w_req_o = 1 and fprf_rd_addr_o/fprf_rd_data_o are muxed from the winner;
  - busy[addr] <= 0;
  - fs_dirty_o <= 1.
- With no grant: fprf_w_req_o = 0 and addr/data are driven to 0.

Simultaneous set and clear:
- A set at issue and a clear at writeback of the same register in one cycle cannot legally occur: the set requires !busy and the clear requires busy.
- If it does occur, the set wins.
- A writeback to a non-busy register is a protocol error: flag it with an assertion, perform the write anyway, busy stays 0.

fs_dirty:
- fs_clean_i clears fs_dirty_o at the edge.
- If a grant occurs in the same cycle, dirty wins (the result is 1).

Decomposition:
- scr1_fprf_ctrl_pkg:
  - type_scr1_fprf_addr_e (logic [4:0]);
  - SCR1_FPRF_NREGS = 32;
  - enum type_scr1_fprf_wsrc_e {SCR1_FPRF_WSRC_FPU, SCR1_FPRF_WSRC_LSU}, used for the RR pointer and grant.
- One sub-module, scr1_fprf_wb_arb: 2-way valid/ready arbiter holding the RR pointer, outputs a one-hot grant.
- The scoreboard, hazard logic and FS logic stay in the top module.

Test Plan:
- Issue FMUL rd=f5 → busy_o[5]=1 the next cycle. Then issue FADD with rs1=f5 → issue_stall_o=1. Then FPU writeback f5=0x3F800000 → fprf_w_req_o=1, addr=5, data=0x3F800000. Next cycle the stall drops and busy_o[5]=0.
- WAW: FLW to f7 pending, issue FDIV rd=f7 → stall until the LSU writeback to f7 is granted; FDIV sets busy[7] in the cycle after.
- Both fpu_wb_vd_i and lsu_wb_vd_i held 4 cycles (distinct addresses), ARB_RR=1 → grants alternate LSU, FPU, LSU, FPU (pointer starts at FPU). The losing side holds its data and is written the following cycle.
- ARB_RR=0 with both valid for 3 cycles → lsu_wb_rdy_o=1 every cycle, fpu_wb_rdy_o=0 until the LSU deasserts valid.
- fs_dirty_o=0 after reset, then first grant → 1. fs_clean_i alone → 0. fs_clean_i together with a grant → 1.
- With busy[3]=1 and busy[9]=1, assert rst for 1 cycle → busy_o=0, no stall for rs1=f3, rdy outputs low during reset.
